rf_multiport: RTL and testbench
===============================

// Module: rf_multiport
// PURPOSE
//  Parametrised multi-port CPU register file with write-to-read bypass and a per-register busy
//  scoreboard. It serves the decode/writeback stages of the pipelined core and replaces the
//  single-read-pair, single-write register file of the single-cycle core.
//  Reads are combinational, so operands are available in the decode cycle.
//  Writes and scoreboard updates commit on the rising clock edge.
// PARAMETERS
//  DW        32  data width, bits
//  DEPTH     32  register count; power of 2, >=2; AW = $clog2(DEPTH)
//  NR        2   read port count, 1..4
//  NW        1   write port count, 1..2
//  BYPASS    1   1: a same-cycle write is visible on the read ports; 0: reads return pre-edge contents
//  ZERO_REG  1   1: reg 0 always reads 0, ignores writes, is never busy
//  INIT_MODE 1   0: reset every reg to 0; 1: reset reg j to j (zero-extended); reg 0 is 0 in both modes
// PORTS
//  clk       in   1        clock, rising edge
//  rst_n     in   1        asynchronous reset, active low
//  rd_addr   in   NR*AW    read addresses, port i at [i*AW +: AW]
//  rd_data   out  NR*DW    read data, port i at [i*DW +: DW]
//  rd_busy   out  NR       port i's register has a pending producer
//  wr_en     in   NW       write enables
//  wr_addr   in   NW*AW    write addresses
//  wr_data   in   NW*DW    write data
//  iss_en    in   1        an instruction issues and will write iss_addr
//  iss_addr  in   AW       destination register of the issuing instruction
//  busy_vec  out  DEPTH    raw scoreboard state, bit j = reg j busy
//  wr_clash  out  1        sticky flag: two write ports hit the same address in one cycle
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - regs take their INIT_MODE values; busy_vec=0; wr_clash=0.
//   - rd_data tracks the reset contents combinationally; rd_busy=0.
//   - Reset asserted mid-operation discards any in-flight write or issue that edge.
//  Write
//   - on posedge, for each port with wr_en=1: reg[wr_addr] <= wr_data.
//   - Same address on both ports: the higher port index wins.
//   - A same-address collision also sets wr_clash, which holds until reset.
//  Read
//   - combinational: rd_data[i] = reg[rd_addr[i]].
//   - With BYPASS=1 and a write port enabled to the same address this cycle:
//     rd_data[i] is that port's wr_data. Highest matching port wins.
//   - With ZERO_REG=1: address 0 always reads 0, with or without bypass.
//  Scoreboard
//   - on posedge, iss_en sets busy[iss_addr].
//   - any wr_en clears busy[wr_addr].
//   - Issue and writeback to the same reg on the same edge: busy ends 1 (new producer wins).
//   - A write to a non-busy reg is legal and leaves busy at 0.
//   - ZERO_REG=1: busy[0] is forced to 0.
//   - rd_busy[i] = busy[rd_addr[i]], except it is 0 when BYPASS=1 and a same-cycle write hits
//     rd_addr[i], because the value is already forwarded.
//  Latency
//   - read: 0 cycles.
//   - write visibility: the same cycle with BYPASS=1, the next cycle with BYPASS=0.
//   - scoreboard update: next cycle.
//  Widths
//   - INIT_MODE=1 values are zero-extended or truncated to DW.
//   - Out-of-range addresses are impossible because DEPTH is a power of 2.
// STRUCTURE
//  - rf_pkg
//    - rf_clog2 function.
//    - INIT_ZERO / INIT_INDEX constants.
//    - default DW/DEPTH localparams shared with decode.
//  - Sub-module rf_scoreboard (DEPTH, NW, ZERO_REG)
//    - holds busy_vec; set/clear priority logic.
//  - Top level: storage array, write-priority mux, bypass mux per read port, wr_clash flop.
// TESTING
//  - Reset INIT_MODE=1, DW=32: read addrs 5 and 31 -> 5, 31; busy_vec=0.
//    Pulse rst_n low between edges -> contents restored immediately.
//  - Write port0 reg7=32'hDEAD_BEEF while reading 7:
//    - BYPASS=1: DEADBEEF in the same cycle.
//    - BYPASS=0: old value 7, then DEADBEEF the next cycle.
//  - NW=2, both ports write reg3 (0x11 on p0, 0x22 on p1) -> reg3=0x22; wr_clash=1 until reset.
//  - ZERO_REG=1: write reg0=0xFFFF_FFFF and issue reg0 -> reads 0; busy_vec[0]=0.
//  - Scoreboard, reg9:
//    - issue reg9 -> busy next cycle.
//    - issue reg9 and write reg9 on the same edge -> stays busy.
//    - write only -> clears.
//    - with BYPASS=1, a read of 9 during that write cycle shows rd_busy=0.
//  - NR=4 random stimulus vs reference model, 10k cycles with random mid-run resets -> zero mismatches.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file and its users.
`timescale 1ns/1ps
package rf_pkg;

  // Reset-content selectors for INIT_MODE.
  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  // Default geometry, shared with the decode stage.
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

  // Ceiling log2, usable in parameter expressions.
  function automatic int rf_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: an issue marks the destination busy, a writeback clears it.
// A same-edge issue and writeback to one register leaves it busy, since the new producer
// is still outstanding.
`timescale 1ns/1ps
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [DEPTH-1:0] busy_vec
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      logic busy_reg;
      logic busy_next;

      // Clear on any writeback, then let an issue on the same edge override it.
      always_comb begin
        busy_next = busy_reg;
        for (int p = 0; p < NW; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(gi))) busy_next = 1'b0;
        end
        if (iss_en && (iss_addr == AW'(gi))) busy_next = 1'b1;
        if ((ZERO_REG != 0) && (gi == 0)) busy_next = 1'b0;
      end

      // Busy bit state register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_reg <= 1'b0;
        else        busy_reg <= busy_next;
      end

      assign busy_vec[gi] = busy_reg;
    end
  endgenerate

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file: combinational reads with optional write-to-read forwarding,
// prioritised multi-port writes, busy scoreboard and a sticky write-collision flag.
`timescale 1ns/1ps
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DW        = RF_DW,
  parameter int DEPTH     = RF_DEPTH,
  parameter int NR        = 2,
  parameter int NW        = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = INIT_INDEX,
  localparam int AW       = rf_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_busy,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [DEPTH-1:0] busy_vec,
  output logic             wr_clash
);

  logic [DW-1:0] reg_q [DEPTH];
  logic          clash_now;
  logic          clash_reg;

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [DW-1:0] INIT_VAL = (INIT_MODE == INIT_INDEX) ? DW'(gi) : '0;
      localparam bit WRITABLE = !((ZERO_REG != 0) && (gi == 0));
      logic [DW-1:0] val_reg;
      logic [DW-1:0] val_next;

      // Write-priority mux: later (higher-index) ports override earlier ones.
      always_comb begin
        val_next = val_reg;
        for (int p = 0; p < NW; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(gi))) val_next = wr_data[p*DW +: DW];
        end
      end

      // Register storage; the hardwired zero register never takes a write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        val_reg <= INIT_VAL;
        else if (WRITABLE) val_reg <= val_next;
      end

      assign reg_q[gi] = val_reg;
    end

    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] data_mux;
      logic          busy_mux;

      assign addr = rd_addr[gi*AW +: AW];

      // Read mux with forwarding; a forwarded value is never reported busy.
      // Forwarding is suppressed during reset so reads show the reset contents.
      always_comb begin
        data_mux = reg_q[addr];
        busy_mux = busy_vec[addr];
        if ((BYPASS != 0) && rst_n) begin
          for (int p = 0; p < NW; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
              data_mux = wr_data[p*DW +: DW];
              busy_mux = 1'b0;
            end
          end
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
          data_mux = '0;
          busy_mux = 1'b0;
        end
      end

      assign rd_data[gi*DW +: DW] = data_mux;
      assign rd_busy[gi]          = busy_mux;
    end
  endgenerate

  // Detect any pair of enabled write ports targeting the same register this cycle.
  always_comb begin
    clash_now = 1'b0;
    for (int p = 0; p < NW; p++) begin
      for (int q = p + 1; q < NW; q++) begin
        if (wr_en[p] && wr_en[q] && (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]))
          clash_now = 1'b1;
      end
    end
  end

  // Sticky collision flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         clash_reg <= 1'b0;
    else if (clash_now) clash_reg <= 1'b1;
  end

  assign wr_clash = clash_reg;

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench: a table of BYPASS=0 vectors, hand sequences for forwarding,
// collisions, the zero register, the scoreboard and async reset, then a randomized
// NR=4/NW=2 run against a behavioural register-file model.
`timescale 1ns/1ps
module tb_rf_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT A: NR=4, NW=2, BYPASS=1
  logic [19:0]  a_rd_addr;
  logic [127:0] a_rd_data;
  logic [3:0]   a_rd_busy;
  logic [1:0]   a_wr_en;
  logic [9:0]   a_wr_addr;
  logic [63:0]  a_wr_data;
  logic         a_iss_en;
  logic [4:0]   a_iss_addr;
  logic [31:0]  a_busy_vec;
  logic         a_wr_clash;

  // DUT B: NR=2, NW=1, BYPASS=0
  logic [9:0]   b_rd_addr;
  logic [63:0]  b_rd_data;
  logic [1:0]   b_rd_busy;
  logic [0:0]   b_wr_en;
  logic [4:0]   b_wr_addr;
  logic [31:0]  b_wr_data;
  logic         b_iss_en;
  logic [4:0]   b_iss_addr;
  logic [31:0]  b_busy_vec;
  logic         b_wr_clash;

  rf_multiport #(.DW(32), .DEPTH(32), .NR(4), .NW(2), .BYPASS(1), .ZERO_REG(1), .INIT_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .iss_en(a_iss_en),
    .iss_addr(a_iss_addr), .busy_vec(a_busy_vec), .wr_clash(a_wr_clash));

  rf_multiport #(.DW(32), .DEPTH(32), .NR(2), .NW(1), .BYPASS(0), .ZERO_REG(1), .INIT_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .iss_en(b_iss_en),
    .iss_addr(b_iss_addr), .busy_vec(b_busy_vec), .wr_clash(b_wr_clash));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model for DUT A ----------------
  int unsigned m_regs [32];
  bit          m_busy [32];
  bit          m_clash;

  function automatic void m_reset();
    for (int j = 0; j < 32; j++) begin
      m_regs[j] = j;
      m_busy[j] = 1'b0;
    end
    m_clash = 1'b0;
  endfunction

  // Commit one clock edge: writes in port order, clears, then issue sets.
  function automatic void m_edge();
    int wa;
    for (int p = 0; p < 2; p++) begin
      if (a_wr_en[p]) begin
        wa = a_wr_addr[p*5 +: 5];
        if (wa != 0) m_regs[wa] = a_wr_data[p*32 +: 32];
        m_busy[wa] = 1'b0;
      end
    end
    if (a_wr_en == 2'b11 && a_wr_addr[4:0] == a_wr_addr[9:5]) m_clash = 1'b1;
    if (a_iss_en) m_busy[a_iss_addr] = 1'b1;
    m_busy[0] = 1'b0;
  endfunction

  task automatic check_a();
    int a;
    logic [31:0] ed;
    logic eb;
    logic [31:0] ebv;
    for (int i = 0; i < 4; i++) begin
      a  = a_rd_addr[i*5 +: 5];
      ed = m_regs[a];
      eb = m_busy[a];
      if (rst_n) begin
        for (int p = 0; p < 2; p++) begin
          if (a_wr_en[p] && a_wr_addr[p*5 +: 5] == 5'(a)) begin
            ed = a_wr_data[p*32 +: 32];
            eb = 1'b0;
          end
        end
      end
      if (a == 0) begin
        ed = '0;
        eb = 1'b0;
      end
      chk($sformatf("rnd rd_data%0d addr %0d", i, a), a_rd_data[i*32 +: 32], ed);
      chk($sformatf("rnd rd_busy%0d addr %0d", i, a), a_rd_busy[i], eb);
    end
    for (int j = 0; j < 32; j++) ebv[j] = m_busy[j];
    chk("rnd busy_vec", a_busy_vec, ebv);
    chk("rnd wr_clash", a_wr_clash, m_clash);
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 5));
  endfunction

  // ---------------- vector table for DUT B ----------------
  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [1:0]  exp_busy;
    logic [31:0] exp_bv;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Expected values are the pre-edge outputs of each row.
    tbl[0] = '{1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd7, 5'd5, 32'd7, 32'd5, 2'b00, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 5'd9, 32'hDEAD_BEEF, 32'd9, 2'b00, 32'h0};
    tbl[2] = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd7, 32'd9, 32'hDEAD_BEEF, 2'b01, 32'h200};
    tbl[3] = '{1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 5'd9, 5'd0, 32'h99, 32'd0, 2'b01, 32'h200};
    tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd31, 32'hAA, 32'd31, 2'b00, 32'h0};
    tbl[5] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd3, 32'd0, 32'd3, 2'b00, 32'h0};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd3, 2'b00, 32'h0};

    rst_n = 1'b0;
    a_rd_addr = {5'd9, 5'd7, 5'd31, 5'd5};
    a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_iss_en = 1'b0; a_iss_addr = '0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_iss_en = 1'b0; b_iss_addr = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset rd_data addr5", a_rd_data[31:0], 32'd5);
    chk("reset rd_data addr31", a_rd_data[63:32], 32'd31);
    chk("reset busy_vec", a_busy_vec, 32'h0);
    chk("reset rd_busy", a_rd_busy, 4'h0);
    chk("reset wr_clash", a_wr_clash, 1'b0);
    $display("reset: addr5=%0d addr31=%0d busy_vec=%0h", a_rd_data[31:0], a_rd_data[63:32], a_busy_vec);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven BYPASS=0 sequence on DUT B ----
    for (int r = 0; r < 7; r++) begin
      b_wr_en[0] = tbl[r].wr_en; b_wr_addr = tbl[r].wr_addr; b_wr_data = tbl[r].wr_data;
      b_iss_en = tbl[r].iss_en; b_iss_addr = tbl[r].iss_addr;
      b_rd_addr = {tbl[r].ra1, tbl[r].ra0};
      #1;
      chk($sformatf("tbl%0d rd0", r), b_rd_data[31:0], tbl[r].exp0);
      chk($sformatf("tbl%0d rd1", r), b_rd_data[63:32], tbl[r].exp1);
      chk($sformatf("tbl%0d rd_busy", r), b_rd_busy, tbl[r].exp_busy);
      chk($sformatf("tbl%0d busy_vec", r), b_busy_vec, tbl[r].exp_bv);
      $display("tbl%0d: rd[%0d]=%0h rd[%0d]=%0h busy=%b bv=%0h", r, tbl[r].ra0, b_rd_data[31:0],
               tbl[r].ra1, b_rd_data[63:32], b_rd_busy, b_busy_vec);
      @(posedge clk);
      @(negedge clk);
    end
    b_wr_en = '0; b_iss_en = 1'b0;
    chk("B wr_clash single port", b_wr_clash, 1'b0);

    // ---- hand sequences on DUT A (BYPASS=1, NW=2) ----
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd7}; a_wr_data = {32'h0, 32'hDEAD_BEEF};
    #1;
    chk("A bypass reg7", a_rd_data[95:64], 32'hDEAD_BEEF);
    chk("A bypass reg7 busy", a_rd_busy[2], 1'b0);
    chk("A unrelated port31", a_rd_data[63:32], 32'd31);
    $display("A write7: rd7=%0h", a_rd_data[95:64]);
    @(posedge clk); @(negedge clk);

    a_wr_en = 2'b11; a_wr_addr = {5'd3, 5'd3}; a_wr_data = {32'h22, 32'h11};
    a_rd_addr[4:0] = 5'd3;
    #1;
    chk("A dual write bypass reg3", a_rd_data[31:0], 32'h22);
    chk("A stored reg7", a_rd_data[95:64], 32'hDEAD_BEEF);
    chk("A clash before edge", a_wr_clash, 1'b0);
    $display("A dual write3: rd3=%0h clash=%b", a_rd_data[31:0], a_wr_clash);
    @(posedge clk); @(negedge clk);

    a_wr_en = 2'b00; a_iss_en = 1'b1; a_iss_addr = 5'd9;
    #1;
    chk("A stored reg3", a_rd_data[31:0], 32'h22);
    chk("A clash set", a_wr_clash, 1'b1);
    chk("A busy_vec before issue", a_busy_vec, 32'h0);
    $display("A issue9: rd3=%0h clash=%b", a_rd_data[31:0], a_wr_clash);
    @(posedge clk); @(negedge clk);

    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd9}; a_wr_data = {32'h0, 32'h99};
    #1;
    chk("A busy_vec after issue", a_busy_vec, 32'h200);
    chk("A rd9 forwarded", a_rd_data[127:96], 32'h99);
    chk("A rd_busy9 forwarded", a_rd_busy[3], 1'b0);
    $display("A issue+write9: bv=%0h rd9=%0h rb=%b", a_busy_vec, a_rd_data[127:96], a_rd_busy[3]);
    @(posedge clk); @(negedge clk);

    a_wr_en = 2'b00; a_iss_en = 1'b0;
    #1;
    chk("A busy kept by same-edge issue", a_busy_vec, 32'h200);
    chk("A rd_busy9", a_rd_busy[3], 1'b1);
    chk("A rd9 stored", a_rd_data[127:96], 32'h99);
    $display("A hold9: bv=%0h rb=%b", a_busy_vec, a_rd_busy[3]);
    @(posedge clk); @(negedge clk);

    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd9}; a_wr_data = {32'h0, 32'h9A};
    #1;
    chk("A rd_busy9 during writeback", a_rd_busy[3], 1'b0);
    chk("A rd9 writeback fwd", a_rd_data[127:96], 32'h9A);
    chk("A busy_vec pre-writeback", a_busy_vec, 32'h200);
    $display("A writeback9: rd9=%0h rb=%b", a_rd_data[127:96], a_rd_busy[3]);
    @(posedge clk); @(negedge clk);

    a_wr_en = 2'b00;
    #1;
    chk("A busy cleared", a_busy_vec, 32'h0);
    chk("A clash sticky", a_wr_clash, 1'b1);
    $display("A cleared9: bv=%0h clash=%b", a_busy_vec, a_wr_clash);

    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'h0, 32'hFFFF_FFFF};
    a_iss_en = 1'b1; a_iss_addr = 5'd0; a_rd_addr[9:5] = 5'd0;
    #1;
    chk("A zero reg no bypass", a_rd_data[63:32], 32'h0);
    chk("A zero reg rd_busy", a_rd_busy[1], 1'b0);
    $display("A write0: rd0=%0h", a_rd_data[63:32]);
    @(posedge clk); @(negedge clk);
    a_wr_en = 2'b00; a_iss_en = 1'b0;
    #1;
    chk("A zero reg stored", a_rd_data[63:32], 32'h0);
    chk("A zero reg not busy", a_busy_vec, 32'h0);
    $display("A after write0: rd0=%0h bv=%0h", a_rd_data[63:32], a_busy_vec);

    // Async reset pulse between edges restores contents immediately.
    #1;
    rst_n = 1'b0;
    #1;
    chk("A pulse reg3", a_rd_data[31:0], 32'd3);
    chk("A pulse reg7", a_rd_data[95:64], 32'd7);
    chk("A pulse reg9", a_rd_data[127:96], 32'd9);
    chk("A pulse clash", a_wr_clash, 1'b0);
    $display("A reset pulse: r3=%0h r7=%0h r9=%0h clash=%b", a_rd_data[31:0], a_rd_data[95:64],
             a_rd_data[127:96], a_wr_clash);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("A post-pulse reg3", a_rd_data[31:0], 32'd3);

    // ---- randomized run against the model ----
    m_reset();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (rst_n && $urandom_range(0, 299) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) a_rd_addr[i*5 +: 5] = rand_addr();
      a_wr_en    = rst_n ? 2'($urandom) : 2'b00;
      a_wr_addr  = {rand_addr(), rand_addr()};
      a_wr_data  = {$urandom, $urandom};
      a_iss_en   = 1'($urandom);
      a_iss_addr = rand_addr();
      if (!rst_n) m_reset();
      #1;
      check_a();
      @(posedge clk);
      if (rst_n) m_edge();
      if (c % 1000 == 0) $display("random cycle %0d: compared %0d", c, n_cmp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
